// File: rtl/roi_crop_stream.sv
// ---------------------------------------------------------------------------
// roi_crop_stream
//
// Purpose:
//   Crops a rectangular region of interest out of a raster-scan pixel stream.
//   Beats are counted into (x, y) frame coordinates starting at the beat that
//   carries in_sof. Beats inside the effective window are forwarded through
//   a 2-entry output FIFO together with window start / row end / window end
//   markers. All other beats are dropped.
//
// Parameters:
//   PIXEL_BIT_WIDTH  bits per channel
//   CHANNELS         channels packed per beat, channel 0 in the LSBs
//   COORD_W          width of coordinate / size inputs and position counters
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   cfg_x1, cfg_y1             window origin column / row
//   cfg_w, cfg_h               window width / height
//   in_cols, in_rows           input frame width / height (both >= 1)
//   pixel_in, in_sof,
//   in_valid, in_ready         input stream (valid/ready handshake)
//   pixel_out, out_sof,
//   out_eol, out_eof,
//   out_valid, out_ready       output stream (valid/ready handshake)
//   frame_count                number of completed output frames
//
// Optional feature:
//   ROI_CROP_FRAME_COUNT_EN    when defined, frame_count counts transferred
//                              out_eof beats (wrapping at 16 bits); otherwise
//                              frame_count is tied to zero.
// ---------------------------------------------------------------------------
module roi_crop_stream #(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int CHANNELS        = 1,
    parameter int COORD_W         = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [COORD_W-1:0]                  cfg_x1,
    input  logic [COORD_W-1:0]                  cfg_y1,
    input  logic [COORD_W-1:0]                  cfg_w,
    input  logic [COORD_W-1:0]                  cfg_h,
    input  logic [COORD_W-1:0]                  in_cols,
    input  logic [COORD_W-1:0]                  in_rows,
    input  logic [PIXEL_BIT_WIDTH*CHANNELS-1:0] pixel_in,
    input  logic                                in_sof,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic [PIXEL_BIT_WIDTH*CHANNELS-1:0] pixel_out,
    output logic                                out_sof,
    output logic                                out_eol,
    output logic                                out_eof,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [15:0]                         frame_count
);

    localparam int DW = PIXEL_BIT_WIDTH * CHANNELS;
    localparam int EW = DW + 3;  // FIFO entry: {pixel, sof, eol, eof}

    localparam logic [COORD_W-1:0] C_ZERO  = {COORD_W{1'b0}};
    localparam logic [COORD_W-1:0] C_ONE   = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W:0]   CE_ONE  = {{COORD_W{1'b0}}, 1'b1};
    localparam logic [EW-1:0]      E_ZERO  = {EW{1'b0}};
    localparam logic [1:0]         OCC_0   = 2'd0;
    localparam logic [1:0]         OCC_1   = 2'd1;
    localparam logic [1:0]         OCC_2   = 2'd2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Frame state and per-frame captured configuration
    state_t               state_r, state_s;
    logic [COORD_W-1:0]   x_r, y_r, x_s, y_s;
    logic [COORD_W-1:0]   x1_r, y1_r, cols_r, rows_r;
    logic [COORD_W-1:0]   x1_s, y1_s, cols_s, rows_s;
    logic [COORD_W:0]     xend_r, yend_r, xend_s, yend_s;

    // Output FIFO: head entry drives the ports directly, slot1 is the second entry
    logic [EW-1:0]        head_r, slot1_r;
    logic [1:0]           occ_r, occ_s;
    logic                 out_valid_r, in_ready_r;

    // Datapath helper signals
    logic                 accept_s, proc_s, keep_s, pop_s;
    logic [COORD_W:0]     cfg_xsum_s, cfg_ysum_s, cfg_xend_s, cfg_yend_s;
    logic [COORD_W-1:0]   cur_x_s, cur_y_s, eff_x1_s, eff_y1_s, eff_cols_s, eff_rows_s;
    logic [COORD_W:0]     eff_xend_s, eff_yend_s;
    logic                 last_col_s, last_row_s;
    logic                 m_sof_s, m_eol_s, m_eof_s;
    logic [EW-1:0]        entry_s;

    assign accept_s = in_valid & in_ready_r;
    assign pop_s    = out_valid_r & out_ready;

    // Clamp the requested window against the frame size (one extra bit, no overflow)
    always_comb begin
        cfg_xsum_s = {1'b0, cfg_x1} + {1'b0, cfg_w};
        cfg_ysum_s = {1'b0, cfg_y1} + {1'b0, cfg_h};
        if (cfg_xsum_s < {1'b0, in_cols}) begin
            cfg_xend_s = cfg_xsum_s;
        end else begin
            cfg_xend_s = {1'b0, in_cols};
        end
        if (cfg_ysum_s < {1'b0, in_rows}) begin
            cfg_yend_s = cfg_ysum_s;
        end else begin
            cfg_yend_s = {1'b0, in_rows};
        end
    end

    // An sof beat is pixel (0,0) of a new frame and uses the live configuration
    always_comb begin
        if (in_sof) begin
            cur_x_s    = C_ZERO;
            cur_y_s    = C_ZERO;
            eff_x1_s   = cfg_x1;
            eff_y1_s   = cfg_y1;
            eff_xend_s = cfg_xend_s;
            eff_yend_s = cfg_yend_s;
            eff_cols_s = in_cols;
            eff_rows_s = in_rows;
        end else begin
            cur_x_s    = x_r;
            cur_y_s    = y_r;
            eff_x1_s   = x1_r;
            eff_y1_s   = y1_r;
            eff_xend_s = xend_r;
            eff_yend_s = yend_r;
            eff_cols_s = cols_r;
            eff_rows_s = rows_r;
        end
    end

    // Window membership and output markers for the beat being accepted
    always_comb begin
        proc_s     = accept_s & (in_sof | (state_r == ACTIVE));
        keep_s     = proc_s
                   & (cur_x_s >= eff_x1_s) & ({1'b0, cur_x_s} < eff_xend_s)
                   & (cur_y_s >= eff_y1_s) & ({1'b0, cur_y_s} < eff_yend_s);
        m_sof_s    = (cur_x_s == eff_x1_s) & (cur_y_s == eff_y1_s);
        m_eol_s    = ({1'b0, cur_x_s} == (eff_xend_s - CE_ONE));
        m_eof_s    = m_eol_s & ({1'b0, cur_y_s} == (eff_yend_s - CE_ONE));
        last_col_s = (cur_x_s == (eff_cols_s - C_ONE));
        last_row_s = (cur_y_s == (eff_rows_s - C_ONE));
        entry_s    = {pixel_in, m_sof_s, m_eol_s, m_eof_s};
    end

    // Next-state / position / config-capture logic
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        x1_s    = x1_r;
        y1_s    = y1_r;
        xend_s  = xend_r;
        yend_s  = yend_r;
        cols_s  = cols_r;
        rows_s  = rows_r;
        case (state_r)
            IDLE, ACTIVE: begin
                if (proc_s) begin
                    if (in_sof) begin
                        x1_s   = cfg_x1;
                        y1_s   = cfg_y1;
                        xend_s = cfg_xend_s;
                        yend_s = cfg_yend_s;
                        cols_s = in_cols;
                        rows_s = in_rows;
                    end else begin
                        x1_s   = x1_r;
                    end
                    if (last_col_s && last_row_s) begin
                        state_s = IDLE;
                        x_s     = C_ZERO;
                        y_s     = C_ZERO;
                    end else if (last_col_s) begin
                        state_s = ACTIVE;
                        x_s     = C_ZERO;
                        y_s     = cur_y_s + C_ONE;
                    end else begin
                        state_s = ACTIVE;
                        x_s     = cur_x_s + C_ONE;
                        y_s     = cur_y_s;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = IDLE;
                x_s     = C_ZERO;
                y_s     = C_ZERO;
            end
        endcase
    end

    // Frame state, position and captured configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            x_r     <= C_ZERO;
            y_r     <= C_ZERO;
            x1_r    <= C_ZERO;
            y1_r    <= C_ZERO;
            xend_r  <= {(COORD_W+1){1'b0}};
            yend_r  <= {(COORD_W+1){1'b0}};
            cols_r  <= C_ONE;
            rows_r  <= C_ONE;
        end else begin
            state_r <= state_s;
            x_r     <= x_s;
            y_r     <= y_s;
            x1_r    <= x1_s;
            y1_r    <= y1_s;
            xend_r  <= xend_s;
            yend_r  <= yend_s;
            cols_r  <= cols_s;
            rows_r  <= rows_s;
        end
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        case ({keep_s, pop_s})
            2'b10:   occ_s = occ_r + OCC_1;
            2'b01:   occ_s = occ_r - OCC_1;
            default: occ_s = occ_r;
        endcase
    end

    // Output FIFO storage; in_ready/out_valid are registered from next occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_r       <= OCC_0;
            head_r      <= E_ZERO;
            slot1_r     <= E_ZERO;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            occ_r       <= occ_s;
            out_valid_r <= (occ_s != OCC_0);
            in_ready_r  <= (occ_s != OCC_2);
            case ({keep_s, pop_s})
                2'b10: begin
                    if (occ_r == OCC_0) begin
                        head_r <= entry_s;
                    end else begin
                        slot1_r <= entry_s;
                    end
                end
                2'b01: begin
                    if (occ_r == OCC_2) begin
                        head_r <= slot1_r;
                    end else begin
                        head_r <= head_r;
                    end
                end
                2'b11: begin
                    // Head leaves; the next-oldest beat moves up, newcomer fills behind it
                    if (occ_r == OCC_1) begin
                        head_r <= entry_s;
                    end else begin
                        head_r  <= slot1_r;
                        slot1_r <= entry_s;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

    assign pixel_out = head_r[EW-1:3];
    assign out_sof   = head_r[2];
    assign out_eol   = head_r[1];
    assign out_eof   = head_r[0];
    assign out_valid = out_valid_r;
    assign in_ready  = in_ready_r;

`ifdef ROI_CROP_FRAME_COUNT_EN
    logic [15:0] frame_count_r;

    // Count window-end beats as they leave the block
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_r <= 16'd0;
        end else if (pop_s && head_r[0]) begin
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_roi_crop_stream.sv
// ---------------------------------------------------------------------------
// tb_roi_crop_stream
//
// Randomised and directed stimulus for roi_crop_stream. Accepted input beats
// are fed to a frame-index based reference model that pushes expected output
// beats into a scoreboard queue; a monitor pops and compares on every output
// transfer, and also checks in_ready/out_valid against the modelled FIFO
// occupancy, output stability under back-pressure and frame_count.
// ---------------------------------------------------------------------------
module tb_roi_crop_stream;

    localparam int PW = 12;
    localparam int CH = 1;
    localparam int CW = 12;
    localparam int DW = PW * CH;

`ifdef ROI_CROP_FRAME_COUNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] cfg_x1 = '0, cfg_y1 = '0, cfg_w = '0, cfg_h = '0;
    logic [CW-1:0] in_cols = 12'd1, in_rows = 12'd1;
    logic [DW-1:0] pixel_in = '0;
    logic          in_sof = 1'b0, in_valid = 1'b0, in_ready;
    logic [DW-1:0] pixel_out;
    logic          out_sof, out_eol, out_eof, out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   frame_count;

    roi_crop_stream #(.PIXEL_BIT_WIDTH(PW), .CHANNELS(CH), .COORD_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cfg_x1(cfg_x1), .cfg_y1(cfg_y1), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .in_cols(in_cols), .in_rows(in_rows),
        .pixel_in(pixel_in), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_out(pixel_out), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus control
    int  or_mode = 0;   // 0: ready=1, 1: toggle, 2: random, 3: ready=0
    bit  gap_en  = 1'b0;
    bit  chk_en  = 1'b0;
    int  fr_cols, fr_rows, fr_x1, fr_y1, fr_w, fr_h;

    // Scoreboard and reference model state
    logic [DW+2:0] sb[$];
    int  pushes = 0, pops = 0;
    bit  m_active = 1'b0;
    int  m_idx, m_cols, m_rows, m_x1, m_y1, m_xe, m_ye;
    longint exp_fc = 0;
    int  pop_cnt = 0, sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;

    // Downstream ready pattern
    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Reference model: frame position from beat index, window from plain arithmetic
    always @(posedge clk) begin
        if (reset) begin
            pushes   = 0;
            m_active = 1'b0;
            sb.delete();
        end else if (in_valid && in_ready) begin
            if (in_sof) begin
                m_cols   = int'(in_cols);
                m_rows   = int'(in_rows);
                m_x1     = int'(cfg_x1);
                m_y1     = int'(cfg_y1);
                m_xe     = (m_x1 + int'(cfg_w) < m_cols) ? m_x1 + int'(cfg_w) : m_cols;
                m_ye     = (m_y1 + int'(cfg_h) < m_rows) ? m_y1 + int'(cfg_h) : m_rows;
                m_idx    = 0;
                m_active = 1'b1;
            end
            if (m_active) begin
                int  x, y;
                bit  s, e, f;
                x = m_idx % m_cols;
                y = m_idx / m_cols;
                if (x >= m_x1 && x < m_xe && y >= m_y1 && y < m_ye) begin
                    s = (x == m_x1) && (y == m_y1);
                    e = (x == m_xe - 1);
                    f = e && (y == m_ye - 1);
                    sb.push_back({pixel_in, s, e, f});
                    pushes++;
                end
                m_idx++;
                if (m_idx == m_cols * m_rows) m_active = 1'b0;
            end
        end
    end

    // Monitor: occupancy-derived handshakes, hold-stability, scoreboard pops
    bit            hold_pend = 1'b0;
    logic [DW+2:0] hold_val;
    always @(negedge clk) begin
        if (reset) begin
            pops      = 0;
            exp_fc    = 0;
            hold_pend = 1'b0;
        end else begin
            if (chk_en) begin
                chk("in_ready_vs_occ", 64'(in_ready), 64'((pushes - pops) < 2));
                chk("out_valid_vs_occ", 64'(out_valid), 64'((pushes - pops) != 0));
                chk("frame_count", 64'(frame_count), 64'(exp_fc[15:0]));
            end
            if (hold_pend && out_valid)
                chk("hold_stable", 64'({pixel_out, out_sof, out_eol, out_eof}), 64'(hold_val));
            if (out_valid && out_ready) begin
                pops++;
                pop_cnt++;
                if (out_sof) sof_cnt++;
                if (out_eol) eol_cnt++;
                if (out_eof) eof_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'({pixel_out, out_sof, out_eol, out_eof}), 64'hDEAD);
                end else begin
                    logic [DW+2:0] e;
                    e = sb.pop_front();
                    chk("beat", 64'({pixel_out, out_sof, out_eol, out_eof}), 64'(e));
                    if (FC_EN && e[0]) exp_fc++;
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {pixel_out, out_sof, out_eol, out_eof};
        end
    end

    task automatic push_beat(input logic [DW-1:0] pix, input logic sof);
        bit done = 1'b0;
        int g = 0;
        while (!done && g < 500) begin
            @(posedge clk);
            #2;
            g++;
            if (gap_en && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_sof   = sof;
                pixel_in = pix;
                if (sof) begin
                    cfg_x1 = CW'(fr_x1); cfg_y1 = CW'(fr_y1);
                    cfg_w  = CW'(fr_w);  cfg_h  = CW'(fr_h);
                    in_cols = CW'(fr_cols); in_rows = CW'(fr_rows);
                end else begin
                    // Config must be ignored away from sof, so scramble it
                    cfg_x1 = CW'($urandom); cfg_y1 = CW'($urandom);
                    cfg_w  = CW'($urandom); cfg_h  = CW'($urandom);
                    in_cols = CW'($urandom_range(1, 4095));
                    in_rows = CW'($urandom_range(1, 4095));
                end
                done = in_ready;
            end
        end
        if (!done) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_in();
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int cols, input int rows, input int x1, input int y1,
                              input int w, input int h, input int nbeats);
        fr_cols = cols; fr_rows = rows; fr_x1 = x1; fr_y1 = y1; fr_w = w; fr_h = h;
        for (int i = 0; i < nbeats; i++) push_beat(DW'($urandom), (i == 0));
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        chk_en   = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pixel_out", 64'(pixel_out), 64'd0);
        chk("rst_markers", 64'({out_sof, out_eol, out_eof}), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        chk_en = 1'b1;
    endtask

    initial begin
        int p0, e0, f0, s0;

        do_reset();

        // 40x40, window (10,10,20,20), out_ready held high
        or_mode = 0; gap_en = 1'b0;
        p0 = pop_cnt; e0 = eol_cnt; f0 = eof_cnt; s0 = sof_cnt;
        send_frame(40, 40, 10, 10, 20, 20, 1600);
        idle_in();
        drain();
        chk("full_beats", 64'(pop_cnt - p0), 64'd400);
        chk("full_eols", 64'(eol_cnt - e0), 64'd20);
        chk("full_eofs", 64'(eof_cnt - f0), 64'd1);
        chk("full_sofs", 64'(sof_cnt - s0), 64'd1);

        // Same frame with out_ready toggling every cycle
        or_mode = 1;
        p0 = pop_cnt; e0 = eol_cnt; f0 = eof_cnt;
        send_frame(40, 40, 10, 10, 20, 20, 1600);
        idle_in();
        drain();
        chk("toggle_beats", 64'(pop_cnt - p0), 64'd400);
        chk("toggle_eols", 64'(eol_cnt - e0), 64'd20);
        chk("toggle_eofs", 64'(eof_cnt - f0), 64'd1);

        // Window clipped by the frame edge: (35,38,10,10) on 40x40
        or_mode = 0;
        p0 = pop_cnt; e0 = eol_cnt; f0 = eof_cnt;
        send_frame(40, 40, 35, 38, 10, 10, 1600);
        idle_in();
        drain();
        chk("clip_beats", 64'(pop_cnt - p0), 64'd10);
        chk("clip_eols", 64'(eol_cnt - e0), 64'd2);
        chk("clip_eofs", 64'(eof_cnt - f0), 64'd1);

        // sof reasserted at index 500 aborts the first frame
        p0 = pop_cnt; e0 = eol_cnt; f0 = eof_cnt;
        send_frame(40, 40, 10, 10, 20, 20, 500);
        send_frame(40, 40, 10, 10, 20, 20, 1600);
        idle_in();
        drain();
        chk("abort_beats", 64'(pop_cnt - p0), 64'd450);
        chk("abort_eols", 64'(eol_cnt - e0), 64'd22);
        chk("abort_eofs", 64'(eof_cnt - f0), 64'd1);

        // Random small frames, windows (incl. empty), gaps, partial frames, back-pressure
        or_mode = 2; gap_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int c, r, n;
            c = $urandom_range(1, 8);
            r = $urandom_range(1, 8);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, c * r) : c * r;
            for (int j = 0; j < $urandom_range(0, 2); j++) push_beat(DW'($urandom), 1'b0);
            send_frame(c, r, $urandom_range(0, 9), $urandom_range(0, 9),
                       $urandom_range(0, 9), $urandom_range(0, 9), n);
        end
        idle_in();
        drain();

        // Fill the FIFO with out_ready low, then reset mid-frame
        or_mode = 3; gap_en = 1'b0;
        repeat (2) @(posedge clk);
        fr_cols = 4; fr_rows = 4; fr_x1 = 0; fr_y1 = 0; fr_w = 4; fr_h = 4;
        push_beat(DW'($urandom), 1'b1);
        push_beat(DW'($urandom), 1'b0);
        idle_in();
        @(negedge clk);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        do_reset();
        or_mode = 0;
        p0 = pop_cnt; f0 = eof_cnt;
        send_frame(4, 4, 1, 1, 2, 2, 16);
        idle_in();
        drain();
        chk("post_reset_beats", 64'(pop_cnt - p0), 64'd4);
        chk("post_reset_eofs", 64'(eof_cnt - f0), 64'd1);
        chk("post_reset_fc", 64'(frame_count), FC_EN ? 64'd1 : 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
